// File: rtl/minterm_func_engine.sv
// Purpose: N-input Boolean function unit held as a 2^N minterm mask, with direct evaluation and a full-table sweep.
// Latency: f_out one cycle after x_in; sweep beats start one cycle after start, done one cycle after the last beat.
// Backpressure: sweep beats use valid/ready; idx and sweep_f hold while ready is low, abort cancels at the next edge.
module minterm_func_engine #(
    parameter int                     N_IN = 3,
    parameter logic [(2**N_IN)-1:0]   MASK = 8'hDC
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_IN-1:0]           x_in,
    output logic                      f_out,
    input  logic [(2**N_IN)-1:0]      mask_in,
    input  logic                      mask_load,
    input  logic                      start,
    input  logic                      abort,
    output logic                      busy,
    output logic                      sweep_valid,
    input  logic                      sweep_ready,
    output logic [N_IN-1:0]           sweep_idx,
    output logic                      sweep_f,
    output logic                      done,
    output logic [N_IN:0]             ones_count
);

    localparam int              NCODE    = 2**N_IN;
    localparam logic [N_IN-1:0] IDX_LAST = N_IN'(NCODE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NCODE-1:0]   r_mask;
    logic [N_IN-1:0]    r_idx;
    logic [N_IN-1:0]    w_idx_nxt;
    logic [N_IN:0]      r_acc;
    logic [N_IN:0]      w_acc_nxt;
    logic [N_IN:0]      r_ones;
    logic [N_IN:0]      w_ones_nxt;
    logic               r_f_out;
    logic               w_in_sweep;
    logic               w_bit;
    logic               w_beat;
    logic               w_last;
    logic               w_mask_we;
    logic [N_IN:0]      w_acc_inc;

    // Sweep-side decode: the mask is frozen while sweeping, so mask[idx] is stable with idx.
    assign w_in_sweep = (r_state == S_SWEEP);
    assign w_bit      = r_mask[r_idx];
    assign w_beat     = w_in_sweep && sweep_ready;
    assign w_last     = (r_idx == IDX_LAST);
    assign w_acc_inc  = r_acc + {{N_IN{1'b0}}, w_bit};
    assign w_mask_we  = (r_state == S_IDLE) && mask_load;

    // Direct evaluation runs in every state from the mask currently held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f_out <= 1'b0;
        end else begin
            r_f_out <= r_mask[x_in];
        end
    end

    // Mask reloads are only taken in IDLE; a load alongside start feeds the sweep that begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= MASK;
        end else if (w_mask_we) begin
            r_mask <= mask_in;
        end
    end

    // FSM state and sweep datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_acc   <= '0;
            r_ones  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_acc   <= w_acc_nxt;
            r_ones  <= w_ones_nxt;
        end
    end

    // Next-state logic: abort beats a same-cycle handshake, and the final count lands with the
    // last accepted beat so ones_count is already valid while done is high.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_acc_nxt   = r_acc;
        w_ones_nxt  = r_ones;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SWEEP;
                    w_idx_nxt   = '0;
                    w_acc_nxt   = '0;
                end
            end
            S_SWEEP: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_beat) begin
                    w_acc_nxt = w_acc_inc;
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                        w_ones_nxt  = w_acc_inc;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs decode straight from registered state; beat fields read zero outside a sweep.
    assign f_out       = r_f_out;
    assign busy        = w_in_sweep;
    assign sweep_valid = w_in_sweep;
    assign sweep_idx   = w_in_sweep ? r_idx : '0;
    assign sweep_f     = w_in_sweep & w_bit;
    assign done        = (r_state == S_DONE);
    assign ones_count  = r_ones;

endmodule

// File: tb/tb_minterm_func_engine.sv
// Randomised bench for minterm_func_engine with a truth-table reference model.
// Direct path checked one cycle after each x_in; sweeps checked beat by beat.
// Ready, stray mask loads and stray starts are randomised during sweeps.
module tb_minterm_func_engine;

    localparam int NC = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] x_in;
    logic       f_out;
    logic [7:0] mask_in;
    logic       mask_load;
    logic       start;
    logic       abort;
    logic       busy;
    logic       sweep_valid;
    logic       sweep_ready;
    logic [2:0] sweep_idx;
    logic       sweep_f;
    logic       done;
    logic [3:0] ones_count;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] m_mask;
    int         m_ones;

    minterm_func_engine #(.N_IN(3), .MASK(8'hDC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .x_in        (x_in),
        .f_out       (f_out),
        .mask_in     (mask_in),
        .mask_load   (mask_load),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .sweep_valid (sweep_valid),
        .sweep_ready (sweep_ready),
        .sweep_idx   (sweep_idx),
        .sweep_f     (sweep_f),
        .done        (done),
        .ones_count  (ones_count)
    );

    always #5 clk = ~clk;

    // Truth-table lookup: F is 1 for code c when bit c of the mask is set.
    function automatic logic fval(input logic [7:0] m, input int code);
        return ((m >> code) & 8'd1) != 8'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"},  busy,        0);
        chk({tag, "_valid"}, sweep_valid, 0);
        chk({tag, "_idx"},   sweep_idx,   0);
        chk({tag, "_sf"},    sweep_f,     0);
        chk({tag, "_done"},  done,        0);
        chk({tag, "_ones"},  ones_count,  m_ones);
    endtask

    task automatic direct_run(input int n, input bit seq);
        int x;
        for (int i = 0; i < n; i++) begin
            x = seq ? (i % NC) : int'($urandom_range(NC - 1));
            x_in = 3'(x);
            step();
            chk("f_out", f_out, fval(m_mask, x));
        end
    endtask

    task automatic load_mask(input logic [7:0] v);
        mask_in   = v;
        mask_load = 1'b1;
        step();
        mask_load = 1'b0;
        m_mask    = v;
    endtask

    // One sweep; abort_at / reset_at select the beat index at which to interrupt (-1 = never).
    task automatic sweep(input int pct, input int abort_at, input int reset_at,
                         input bit load_with_start, input logic [7:0] new_mask);
        int exp_idx = 0;
        int steps   = 0;
        bit rdy;
        bit finished = 1'b0;
        start = 1'b1;
        if (load_with_start) begin
            mask_in   = new_mask;
            mask_load = 1'b1;
        end
        step();
        start     = 1'b0;
        mask_load = 1'b0;
        if (load_with_start) m_mask = new_mask;
        while (!finished && steps < 300) begin
            chk("sw_busy",  busy,        1);
            chk("sw_valid", sweep_valid, 1);
            chk("sw_idx",   sweep_idx,   exp_idx);
            chk("sw_f",     sweep_f,     fval(m_mask, exp_idx));
            chk("sw_done",  done,        0);
            if (exp_idx == reset_at) begin
                rst_n = 1'b0;
                #1;
                m_mask = 8'hDC;
                m_ones = 0;
                chk("rst_f_out", f_out, 0);
                chk_quiet("rst");
                rst_n = 1'b1;
                return;
            end
            if (exp_idx == abort_at) begin
                abort       = 1'b1;
                sweep_ready = 1'b1;
                step();
                abort = 1'b0;
                chk_quiet("abort");
                return;
            end
            rdy         = ($urandom_range(99) < pct);
            sweep_ready = rdy;
            mask_load   = 1'($urandom_range(1));
            mask_in     = 8'($urandom);
            start       = 1'($urandom_range(1));
            step();
            steps++;
            mask_load = 1'b0;
            start     = 1'b0;
            if (rdy) begin
                if (exp_idx == NC - 1) finished = 1'b1;
                else exp_idx++;
            end
        end
        m_ones = $countones(m_mask);
        chk("end_done",  done,        1);
        chk("end_busy",  busy,        0);
        chk("end_valid", sweep_valid, 0);
        chk("end_ones",  ones_count,  m_ones);
        if (pct >= 100) chk("latency", steps, NC);
        sweep_ready = 1'($urandom_range(1));
        step();
        chk_quiet("post");
    endtask

    initial begin
        rst_n       = 1'b0;
        x_in        = '0;
        mask_in     = '0;
        mask_load   = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        sweep_ready = 1'b0;
        m_mask      = 8'hDC;
        m_ones      = 0;
        #12;
        chk("reset_f_out", f_out, 0);
        chk_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        direct_run(NC, 1'b1);
        direct_run(20, 1'b0);

        sweep(100, -1, -1, 1'b0, 8'h00);
        sweep(50,  -1, -1, 1'b0, 8'h00);
        sweep(100,  3, -1, 1'b0, 8'h00);
        direct_run(4, 1'b0);

        load_mask(8'hFF);
        sweep(70, -1, -1, 1'b0, 8'h00);
        load_mask(8'h00);
        sweep(100, -1, -1, 1'b0, 8'h00);
        sweep(60, -1, -1, 1'b1, 8'h5A);
        direct_run(10, 1'b0);

        load_mask(8'hFF);
        sweep(100, -1, 4, 1'b0, 8'h00);
        step();
        chk_quiet("after_rst");
        direct_run(NC, 1'b1);
        sweep(100, -1, -1, 1'b0, 8'h00);

        for (int r = 0; r < 6; r++) begin
            load_mask(8'($urandom));
            direct_run(6, 1'b0);
            sweep(int'($urandom_range(30, 100)), -1, -1, 1'b0, 8'h00);
        end
        sweep(40, int'($urandom_range(NC - 1)), -1, 1'b1, 8'($urandom));
        direct_run(6, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
